// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core with request/ready handshakes to instruction and
// data memories. One instruction is in flight at a time. The core stops for
// good on a taken self-jump; only reset brings it back.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              imem_ready,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {FETCH, DECODE, MREAD, EXECUTE, MWRITE, HALT} state_t;

  state_t              state, state_nx;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   a_reg, d_reg, mdr, wdata;
  logic [ADDR_W-1:0]   waddr;
  logic                halt_pend;   // the pending M write belongs to a self-jump
  logic [DATA_W-1:0]   alu_x, alu_y, alu_out;
  logic                zr, ng, jump, self_jump;
  logic [PC_W-1:0]     pc_inc, jmp_tgt;

  assign pc_inc    = pc + PC_W'(1);
  assign jmp_tgt   = a_reg[PC_W-1:0];
  assign zr        = (alu_out == '0);
  assign ng        = alu_out[DATA_W-1];
  assign jump      = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~zr & ~ng);
  assign self_jump = jump && (jmp_tgt == pc);

  // Hack ALU: x = D, y = A or M, controlled by zx,nx,zy,ny,f,no = ir[11:6]
  always_comb begin
    alu_x = ir[11] ? '0 : d_reg;
    if (ir[10]) alu_x = ~alu_x;
    alu_y = ir[12] ? mdr : a_reg;
    if (ir[9]) alu_y = '0;
    if (ir[8]) alu_y = ~alu_y;
    alu_out = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir[6]) alu_out = ~alu_out;
  end

  // Next-state logic and the retire pulse in the last cycle of each instruction
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      FETCH:   if (imem_ready) state_nx = DECODE;
      DECODE: begin
        if (!ir[15]) begin
          retire   = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = ir[12] ? MREAD : EXECUTE;
        end
      end
      MREAD:   if (dmem_ready) state_nx = EXECUTE;
      EXECUTE: begin
        if (ir[3]) begin
          state_nx = MWRITE;
        end else begin
          retire   = 1'b1;
          state_nx = self_jump ? HALT : FETCH;
        end
      end
      MWRITE: begin
        if (dmem_ready) begin
          retire   = 1'b1;
          state_nx = halt_pend ? HALT : FETCH;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
    if (reset) retire = 1'b0;
  end

  // Requests are Moore outputs, killed combinationally while reset is high
  assign imem_req   = (state == FETCH)  && !reset;
  assign dmem_rd    = (state == MREAD)  && !reset;
  assign dmem_wr    = (state == MWRITE) && !reset;
  assign imem_addr  = pc;
  assign dmem_addr  = (state == MWRITE) ? waddr : a_reg[ADDR_W-1:0];
  assign dmem_wdata = wdata;
  assign halted     = (state == HALT);

  // Architectural state; EXECUTE uses the A value held at its entry for
  // the A update, the write address and the jump target alike
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      a_reg     <= '0;
      d_reg     <= '0;
      ir        <= '0;
      mdr       <= '0;
      waddr     <= '0;
      wdata     <= '0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH:  if (imem_ready) ir <= imem_data;
        DECODE: begin
          if (!ir[15]) begin
            a_reg <= {{(DATA_W-15){1'b0}}, ir[14:0]};
            pc    <= pc_inc;
          end
        end
        MREAD:  if (dmem_ready) mdr <= dmem_rdata;
        EXECUTE: begin
          if (ir[5]) a_reg <= alu_out;
          if (ir[4]) d_reg <= alu_out;
          pc        <= jump ? jmp_tgt : pc_inc;
          waddr     <= a_reg[ADDR_W-1:0];
          wdata     <= alu_out;
          halt_pend <= self_jump;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: memories with random wait states serve the core, and
// an instruction-level Hack interpreter predicts pc/A/D/memory after every retire.
module tb_hack_cpu_mc;
  localparam int DW = 16, AW = 15, PW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          imem_req, imem_ready;
  logic [PW-1:0] imem_addr, pc;
  logic [15:0]   imem_data;
  logic          dmem_rd, dmem_wr, dmem_ready;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          retire, halted;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .retire(retire), .halted(halted)
  );

  // Narrow-pc instance for the wrap check; it executes @1 forever
  logic          reset4 = 1'b1;
  logic          req4, rd4, wr4, ret4, hlt4;
  logic [3:0]    iaddr4, pc4;
  logic [AW-1:0] daddr4;
  logic [DW-1:0] wd4;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .PC_W(4)) dut4 (
    .clk(clk), .reset(reset4),
    .imem_req(req4), .imem_addr(iaddr4), .imem_data(16'h0001), .imem_ready(1'b1),
    .dmem_rd(rd4), .dmem_wr(wr4), .dmem_addr(daddr4), .dmem_wdata(wd4),
    .dmem_rdata('0), .dmem_ready(1'b1),
    .pc(pc4), .retire(ret4), .halted(hlt4)
  );

  logic [15:0]   rom   [0:32767];
  logic [DW-1:0] e_ram [0:32767];   // memory the core actually sees
  logic [DW-1:0] m_ram [0:32767];   // memory of the reference interpreter

  int n_assert = 0, n_fail = 0;

  // reference architectural state
  logic [PW-1:0] m_pc;
  logic [DW-1:0] m_a, m_d;
  bit            m_halt;
  bit            exp_wr;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;

  // environment state
  int            wait_mode = 0, dwait_fixed = -1;
  bit            pend;
  int            cnt;
  logic [PW-1:0] hold_i;
  logic [AW-1:0] hold_d, last_waddr, last_raddr;
  logic [DW-1:0] hold_w, last_wdata;
  int            cyc, ret_cyc, prev_ret_cyc, n_ret, rd_cyc, wr_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    if (c[5]) x = 16'h0;
    if (c[4]) x = ~x;
    if (c[3]) y = 16'h0;
    if (c[2]) y = ~y;
    r = c[1] ? x + y : x & y;
    if (c[0]) r = ~r;
    return r;
  endfunction

  // Execute one whole instruction at ISA level
  task automatic model_step();
    logic [15:0] ins, y, r, old_a;
    bit taken;
    ins = rom[m_pc];
    exp_wr = 1'b0;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      old_a = m_a;
      y = ins[12] ? m_ram[old_a[14:0]] : old_a;
      r = alu(ins[11:6], m_d, y);
      if (ins[3]) begin
        exp_wr = 1'b1; exp_waddr = old_a[14:0]; exp_wdata = r;
        m_ram[old_a[14:0]] = r;
      end
      if (ins[5]) m_a = r;
      if (ins[4]) m_d = r;
      taken = (ins[2] && r[15]) || (ins[1] && r == 16'h0) || (ins[0] && r != 16'h0 && !r[15]);
      if (taken) begin
        if (old_a[14:0] == m_pc) m_halt = 1'b1;
        m_pc = old_a[14:0];
      end else begin
        m_pc = m_pc + 15'd1;
      end
    end
  endtask

  function automatic int pick_wait(input bit is_data);
    if (wait_mode != 0) return $urandom_range(0, 3);
    if (is_data && dwait_fixed >= 0) return dwait_fixed;
    return 0;
  endfunction

  // One clock: entered just after a falling edge, returns at the next one
  task automatic cycle();
    bit rdy, busy, retired;
    busy = imem_req || dmem_rd || dmem_wr;
    if (busy) begin
      if (!pend) begin
        pend = 1'b1; cnt = pick_wait(dmem_rd || dmem_wr);
        hold_i = imem_addr; hold_d = dmem_addr; hold_w = dmem_wdata;
      end else begin
        if (imem_req) chk("imem_addr_hold", imem_addr, hold_i);
        if (dmem_rd || dmem_wr) chk("dmem_addr_hold", dmem_addr, hold_d);
        if (dmem_wr) chk("wdata_hold", dmem_wdata, hold_w);
      end
      rdy = (cnt == 0);
      if (!rdy) cnt--;
    end else begin
      rdy = (wait_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    imem_ready = rdy;
    dmem_ready = rdy;
    imem_data  = rom[imem_addr];
    dmem_rdata = e_ram[dmem_addr];
    #1;
    chk("req_onehot", 32'($countones({imem_req, dmem_rd, dmem_wr}) <= 1), 1);
    if (imem_req) chk("imem_addr", imem_addr, m_pc);
    if (dmem_rd) begin
      chk("rd_addr", dmem_addr, m_a[14:0]);
      rd_cyc++; last_raddr = dmem_addr;
    end
    if (dmem_wr) wr_cyc++;
    if (dmem_wr && rdy) begin
      e_ram[dmem_addr] = dmem_wdata;
      last_waddr = dmem_addr; last_wdata = dmem_wdata;
      chk("wr_retire", retire, 1);
    end
    retired = retire;
    if (retire) begin
      model_step();
      n_ret++; prev_ret_cyc = ret_cyc; ret_cyc = cyc;
      chk("wr_expected", 32'(dmem_wr && rdy), 32'(exp_wr));
      if (exp_wr) begin
        chk("wr_addr", dmem_addr, exp_waddr);
        chk("wr_data", dmem_wdata, exp_wdata);
      end
    end
    if (busy && rdy) pend = 1'b0;
    @(posedge clk); #1;
    if (retired) begin
      chk("pc", pc, m_pc);
      chk("a", dut.a_reg, m_a);
      chk("d", dut.d_reg, m_d);
      chk("halted", halted, 32'(m_halt));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; pend = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc", pc, 0);
    chk("rst_a", dut.a_reg, 0);
    chk("rst_d", dut.d_reg, 0);
    chk("rst_ir", dut.ir, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    chk("rst_reqs", {imem_req, dmem_rd, dmem_wr}, 0);
    m_pc = '0; m_a = '0; m_d = '0; m_halt = 1'b0;
    cyc = 0; ret_cyc = 0; prev_ret_cyc = 0; rd_cyc = 0; wr_cyc = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic run_retires(input int n);
    int target, lim;
    target = n_ret + n;
    lim = n * 40;
    for (int i = 0; i < lim && n_ret < target && !m_halt; i++) cycle();
    if (!m_halt) chk("retire_count", n_ret, target);
  endtask

  task automatic halt_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      chk("halt_reqs", {imem_req, dmem_rd, dmem_wr}, 0);
      chk("halt_hold", halted, 1);
      chk("halt_pc", pc, m_pc);
    end
  endtask

  initial begin
    int k;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_data = '0; dmem_rdata = '0;
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0; e_ram[i] = '0; m_ram[i] = '0;
    end

    // ---- directed program, zero wait ----
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hFDE8;
    rom[4] = 16'h0064; rom[5] = 16'hFC10; rom[6] = 16'hEE90; rom[7] = 16'h0014;
    rom[8] = 16'hE304; rom[20] = 16'hEA90; rom[21] = 16'h0007; rom[22] = 16'hE301;
    e_ram[100] = 16'h0009; m_ram[100] = 16'h0009;
    do_reset();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    run_retires(1);
    chk("ainst_cycles", ret_cyc, 1);
    chk("ainst_a", dut.a_reg, 16'h0005);
    chk("ainst_pc", pc, 1);
    run_retires(1);
    chk("cinst_gap", ret_cyc - prev_ret_cyc, 3);
    chk("d_eq_a", dut.d_reg, 16'h0005);
    chk("d_eq_a_pc", pc, 2);
    chk("no_dmem", rd_cyc + wr_cyc, 0);
    run_retires(2);
    chk("amp1_gap", ret_cyc - prev_ret_cyc, 5);
    chk("amp1_waddr", last_waddr, 100);
    chk("amp1_wdata", last_wdata, 16'h000A);
    chk("amp1_a", dut.a_reg, 16'h000A);
    e_ram[100] = 16'h1234; m_ram[100] = 16'h1234;
    run_retires(1);
    rd_cyc = 0; dwait_fixed = 3;
    run_retires(1);
    dwait_fixed = -1;
    chk("dm_rd_cycles", rd_cyc, 4);
    chk("dm_raddr", last_raddr, 100);
    chk("dm_gap", ret_cyc - prev_ret_cyc, 7);
    chk("dm_d", dut.d_reg, 16'h1234);
    run_retires(3);
    chk("jlt_taken_pc", pc, 20);
    run_retires(3);
    chk("jgt_not_taken_pc", pc, 23);
    chk("jgt_d", dut.d_reg, 0);

    // ---- halt on self-jump ----
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0003; rom[3] = 16'hEA87;
    do_reset();
    run_retires(10);
    chk("halt_model", 32'(m_halt), 1);
    chk("halted", halted, 1);
    chk("halt_pc3", pc, 3);
    halt_quiet(6);

    // ---- reset abandons an in-progress write ----
    rom[0] = 16'h0064; rom[1] = 16'hE308;
    do_reset();
    run_retires(1);
    dwait_fixed = 5;
    for (int i = 0; i < 8 && !dmem_wr; i++) cycle();
    chk("mwrite_seen", dmem_wr, 1);
    reset = 1'b1;
    #1;
    chk("rst_kills_wr", dmem_wr, 0);
    chk("rst_kills_req", imem_req, 0);
    dwait_fixed = -1;

    // ---- random programs with random wait states ----
    wait_mode = 1;
    for (int i = 0; i < 32768; i++) begin
      k = $urandom_range(0, 7);
      if (k < 2)       rom[i] = {1'b0, 15'($urandom_range(0, 63))};
      else if (k == 2) rom[i] = {1'b0, 15'($urandom)};
      else             rom[i] = {3'b111, 13'($urandom)};
    end
    for (int r = 0; r < 4; r++) begin
      do_reset();
      run_retires(150);
      if (m_halt) halt_quiet(4);
    end

    // ---- pc wrap with a 4-bit pc ----
    @(negedge clk);
    reset4 = 1'b0;
    k = 0;
    for (int i = 0; i < 80 && k < 16; i++) begin
      @(negedge clk);
      if (ret4) begin
        k++;
        @(posedge clk); #1;
        if (k == 15) chk("pc4_15", pc4, 15);
        if (k == 16) chk("pc4_wrap", pc4, 0);
      end
    end
    chk("pc4_retires", k, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
